// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for pointer encoders, decoders and their benches.
package gray_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int MAX_WIDTH = 32;

   // Callers zero-extend to MAX_WIDTH; zeros above the live bits leave both results unchanged.
   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
      logic [MAX_WIDTH-1:0] b;
      b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
      for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray encoder, reusable wherever pointers are encoded.
module binary_to_gray
   import gray_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs plus a wrap pulse.
// Define GRAY_CNT_SAT_EN to saturate at the range ends instead of wrapping.
module gray_counter
   import gray_pkg::*;
#(
   parameter int              WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RST_VAL)));

   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_next;
   logic             wrap_next;
   logic             at_edge;

   assign at_edge = up ? (bin_out == MAX_VAL) : (bin_out == '0);

`ifdef GRAY_CNT_SAT_EN
   // Set by a blocked step, cleared once the count moves, so repeated blocked steps pulse once.
   logic sat_seen;
   logic sat_seen_next;
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      bin_next  = bin_out;
      wrap_next = 1'b0;
`ifdef GRAY_CNT_SAT_EN
      sat_seen_next = sat_seen;
`endif
      if (load) begin
         bin_next = load_val;
      end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
         if (at_edge) begin
            wrap_next     = ~sat_seen;
            sat_seen_next = 1'b1;
         end else begin
            bin_next = up ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1);
         end
`else
         bin_next  = up ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1);
         wrap_next = at_edge;
`endif
      end
`ifdef GRAY_CNT_SAT_EN
      if (bin_next != bin_out) begin
         sat_seen_next = 1'b0;
      end
`endif
   end

   // Gray is encoded from the next binary value so gray_out comes straight off a flop.
   binary_to_gray #(.WIDTH(WIDTH)) u_b2g (
      .bin  (bin_next),
      .gray (gray_next)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_out  <= RST_VAL;
         gray_out <= RST_GRAY;
         wrap     <= 1'b0;
      end else begin
         bin_out  <= bin_next;
         gray_out <= gray_next;
         wrap     <= wrap_next;
      end
   end

`ifdef GRAY_CNT_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_seen <= 1'b0;
      end else begin
         sat_seen <= sat_seen_next;
      end
   end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: stimulus pushes model predictions, a monitor pops and compares.
module tb_gray_counter;
   import gray_pkg::*;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] bin_out;
   logic [W-1:0] gray_out;
   logic         wrap;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int   bin;
      int   gray;
      int   prev_gray;
      logic wrap;
      logic stepped;
   } exp_t;

   exp_t exp_q[$];
   int   gray_tab[0:MAXV];
   int   m_count;
   logic m_sat_seen;

   gray_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bin_out  (bin_out),
      .gray_out (gray_out),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
      end
   endtask

   // Reflected-binary construction: the second half is the mirrored first half with a new top bit.
   task automatic build_gray_table();
      gray_tab[0] = 0;
      for (int k = 1; k <= W; k++) begin
         for (int i = 0; i < (1 << (k - 1)); i++) begin
            gray_tab[(1 << k) - 1 - i] = gray_tab[i] | (1 << (k - 1));
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the predicted post-edge outputs.
   task automatic step(input logic e, input logic u, input logic ld, input int lv);
      exp_t x;
      int   n;
      logic w;
      logic blocked;
      @(negedge clk);
      en = e; up = u; load = ld; load_val = W'(lv);
      n = m_count; w = 1'b0; blocked = 1'b0;
      if (ld) begin
         n = lv;
      end else if (e) begin
         if ((u && m_count == MAXV) || (!u && m_count == 0)) begin
`ifdef GRAY_CNT_SAT_EN
            blocked = 1'b1;
            w = !m_sat_seen;
`else
            n = u ? 0 : MAXV;
            w = 1'b1;
`endif
         end else begin
            n = u ? m_count + 1 : m_count - 1;
         end
      end
      if (n != m_count) m_sat_seen = 1'b0;
      if (blocked) m_sat_seen = 1'b1;
      x.prev_gray = gray_tab[m_count];
      x.bin       = n;
      x.gray      = gray_tab[n];
      x.wrap      = w;
      x.stepped   = !ld && e && (n != m_count);
      m_count     = n;
      exp_q.push_back(x);
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      #2 rst_n = 1'b0;
      en = 1'b0; up = 1'b0; load = 1'b0;
      #1;
      check("async_rst_bin", int'(bin_out), 0);
      check("async_rst_gray", int'(gray_out), gray_tab[0]);
      check("async_rst_wrap", int'(wrap), 0);
      m_count = 0;
      m_sat_seen = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: the counter presents a fresh output every cycle, sampled 1 time unit after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("bin_out", int'(bin_out), x.bin);
            check("gray_out", int'(gray_out), x.gray);
            check("wrap", int'(wrap), int'(x.wrap));
            check("gray_decode", int'(gray2bin(MAX_WIDTH'(gray_out))), x.bin);
            if (x.stepped) begin
               check("one_bit_flip", $countones(W'(gray_out) ^ W'(x.prev_gray)), 1);
            end
         end
      end
   end

   initial begin
      build_gray_table();
      m_count = 0;
      m_sat_seen = 1'b0;

      #12;
      check("rst_bin", int'(bin_out), 0);
      check("rst_gray", int'(gray_out), 0);
      check("rst_wrap", int'(wrap), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0);

      // Full up-count cycle through the wrap (saturates at the top with the option).
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 0);

      // Down from zero, then one more down step.
      step(1'b0, 1'b0, 1'b1, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);

      // Load beats enable, then hold.
      step(1'b1, 1'b1, 1'b1, 4'b1010);
      step(1'b0, 1'b1, 1'b0, 0);

      // Direction toggles at 0101.
      step(1'b0, 1'b0, 1'b1, 4'b0101);
      step(1'b1, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 0);

      // Top boundary approach and repeated steps against it.
      step(1'b0, 1'b0, 1'b1, 4'b1110);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 0);

      // Reset right behind a boundary step, while any wrap pulse is still high.
      step(1'b0, 1'b0, 1'b1, 0);
      step(1'b1, 1'b0, 1'b0, 0);
      async_reset_check();
      step(1'b0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 0);
      async_reset_check();

      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), int'($urandom_range(0, MAXV)));
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parameterised up/down counter that publishes its count in Gray code. It is the encode-direction companion of the team's Gray-to-binary decoder.
- Holds a binary count internally and drives a registered Gray output: exactly one bit changes per step, suitable for async-FIFO pointers and CDC crossings.
- Sits on the write or read side of a pointer crossing. The far side decodes with the existing Gray-to-binary block.

Parameters:
- WIDTH, 4, counter and code width in bits (minimum 2).
- RST_VAL, 0, binary value loaded on reset. Must be less than 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable. One step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  synchronous load of load_val. Has priority over en.
- load_val  input  WIDTH  binary value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out, equal to bin_out ^ (bin_out >> 1).
- wrap  output  1  registered one-cycle pulse on the edge where the count wraps (or saturates, with the option enabled).

Behaviour:
- Reset (rst_n=0, asynchronous, no clock required):
  - bin_out = RST_VAL.
  - gray_out = RST_VAL ^ (RST_VAL >> 1).
  - wrap = 0.
- Release: the first update occurs at the first rising clk edge with rst_n=1.
- Next-state priority, evaluated each rising edge:
  - load=1: bin_next = load_val.
  - Else en=1 and up=1: bin_next = bin_out + 1, modulo 2^WIDTH.
  - Else en=1 and up=0: bin_next = bin_out - 1, modulo 2^WIDTH.
  - Else: hold.
- Gray register: gray_out is registered from bin_to_gray(bin_next), never from a combinational decode of bin_out. Both outputs update on the same edge, so latency from en to output change is 1 cycle. gray_out must be glitch-free because it is a flop output.
- Single-bit property: for every en step with load=0, popcount(gray_out_old ^ gray_out_new) = 1, including across wrap. A load may change any number of bits.
- wrap:
  - Goes to 1 for exactly one cycle when an en step moves 2^WIDTH-1 → 0 (up) or 0 → 2^WIDTH-1 (down).
  - A load never asserts wrap, even when load_val crosses a boundary.
- Simultaneous load and en: load wins. No step occurs and wrap = 0.
- Direction change: a toggle of up takes effect on the same edge, with no dead cycle.
- Reset mid-operation: asynchronous return to reset values. Any in-flight wrap pulse is cleared immediately.
- All arithmetic is unsigned, WIDTH bits wide. There are no X-sensitive paths; load_val is ignored when load=0.

Optional Feature:
- Macro: GRAY_CNT_SAT_EN.
- Defined:
  - The counter saturates at 2^WIDTH-1 (up) and at 0 (down). A step at the boundary holds the value.
  - wrap is repurposed as a saturation pulse. It goes high for one cycle on the first blocked step only, and stays low on subsequent blocked steps until the count leaves the boundary.
  - The single-bit property is unaffected, because holding changes zero bits.
- Not defined: modulo wrap as described above.

Decomposition:
- Package gray_pkg:
  - function bin2gray(WIDTH-bit), returns b ^ (b >> 1).
  - function gray2bin, a prefix-XOR shared with the decoder and the bench model.
  - localparam DEF_WIDTH = 4.
- Sub-module binary_to_gray:
  - Purely combinational, WIDTH-parameterised, calls bin2gray.
  - Instantiated once on bin_next ahead of the gray_out flops.
  - Reusable wherever pointers are encoded.

Test Plan (WIDTH=4, RST_VAL=0):
1. Reset: hold rst_n=0, then release -> bin_out=0000, gray_out=0000, wrap=0. Asserting rst_n low between edges mid-count clears the outputs immediately.
2. Up count: en=1, up=1 for 16 cycles -> gray_out sequence 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
   - wrap=1 only on the 1000→0000 edge.
   - The bench checks exactly one bit flips per step.
3. Down count from 0: en=1, up=0 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle. The next step gives 1110/1001 with wrap=0.
4. Load priority: load=1, load_val=1010, en=1 -> bin_out=1010, gray_out=1111, wrap=0. With en=0 the next cycle, the count holds.
5. Direction toggle: at bin 0101, alternate up=1,0,1 -> 0110 (gray 0101), 0101 (gray 0111), 0110 (gray 0101), each one cycle after the input.
6. Saturate (GRAY_CNT_SAT_EN defined): load 1110, then up-step three times -> 1111, 1111, 1111, gray_out=1000 throughout.
   - wrap pulses only on the second step, the first blocked one.
   - Down from 0 holds at 0000 with a single pulse.
